mem_axi_arbiter: RTL and testbench

Parametrised arbiter that merges NUM_MASTERS cache/uncached masters onto the single AXI3 master port of the CPU. Read and write channels are arbitrated independently, each with its own grant FSM, so a data-cache write-back can overlap an instruction-cache refill. Grants are held for a whole burst, and the winner's index is carried on arid/awid/wid. The block sits between the Icache/Dcache/uncached units and the SoC AXI interconnect.

---
 rtl/mem_arb_pkg.sv | 39 +++
 rtl/rr_arbiter.sv | 56 +++++
 rtl/mem_axi_arbiter.sv | 258 +++++++++++++++++++++++++
 tb/tb_mem_axi_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for mem_axi_arbiter: channel state enums,
// fixed AXI3 attribute values and grant-index sizing helpers.
package mem_arb_pkg;

    // Read channel grant FSM.
    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } rd_state_e;

    // Write channel grant FSM.
    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_DATA = 2'd2,
        W_RESP = 2'd3
    } wr_state_e;

    // AXI3 ID width on the SoC side; the master index is zero-extended into it.
    localparam int AXI_ID_W = 4;

    // Attributes driven as constants on every transaction.
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_LOCK_NORMAL = 2'b00;
    localparam logic [3:0] AXI_CACHE_NONE  = 4'b0000;
    localparam logic [2:0] AXI_PROT_NONE   = 3'b000;

    // Width of a master index, $clog2(n), kept at least one bit wide.
    function automatic int grant_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // AxSIZE encoding for a full-width beat of data_w bits.
    function automatic logic [2:0] axi_size(input int data_w);
        return 3'($clog2(data_w / 8));
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational request arbiter returning a one-hot grant and its index.
// MEM_ARB_ROUND_ROBIN_EN defined: search starts at ptr and wraps around.
// MEM_ARB_ROUND_ROBIN_EN undefined: fixed priority, lowest index wins, ptr ignored.
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = grant_idx_w(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Pick the first requester at or after ptr, wrapping modulo N.
    always_comb begin : rr_pick
        int  idx;
        logic found;
        // NOTE: every output and temporary gets a default before the loop so
        // no path through this block leaves a value held, which would infer a latch.
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IDX_W'(idx);
            end
        end
    end
`else
    // Pick the lowest-indexed requester.
    always_comb begin : fixed_pick
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && req[k]) begin
                found     = 1'b1;
                grant[k]  = 1'b1;
                grant_idx = IDX_W'(k);
            end
        end
    end

    logic unused_ptr;
    assign unused_ptr = ^ptr;
`endif

endmodule

// File: rtl/mem_axi_arbiter.sv
// Merges NUM_MASTERS cache/uncached masters onto one AXI3 master port.
// Read and write channels have independent grant FSMs; a grant is held for
// the whole burst and the winner's index travels on arid/awid/wid.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin arbitration with separate
// read/write pointers; when undefined, fixed priority (master 0 first).
module mem_axi_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic                            clk,
    input  logic                            resetn,
    // Master side, read
    input  logic [NUM_MASTERS-1:0]          m_arvalid,
    output logic [NUM_MASTERS-1:0]          m_arready,
    input  logic [NUM_MASTERS*ADDR_W-1:0]   m_araddr,
    input  logic [NUM_MASTERS*4-1:0]        m_arlen,
    output logic [NUM_MASTERS-1:0]          m_rvalid,
    output logic [NUM_MASTERS-1:0]          m_rlast,
    output logic [DATA_W-1:0]               m_rdata,
    // Master side, write
    input  logic [NUM_MASTERS-1:0]          m_awvalid,
    output logic [NUM_MASTERS-1:0]          m_awready,
    input  logic [NUM_MASTERS*ADDR_W-1:0]   m_awaddr,
    input  logic [NUM_MASTERS*4-1:0]        m_awlen,
    input  logic [NUM_MASTERS*DATA_W-1:0]   m_wdata,
    input  logic [NUM_MASTERS*DATA_W/8-1:0] m_wstrb,
    input  logic [NUM_MASTERS-1:0]          m_wvalid,
    input  logic [NUM_MASTERS-1:0]          m_wlast,
    output logic [NUM_MASTERS-1:0]          m_wready,
    output logic [NUM_MASTERS-1:0]          m_bvalid,
    // AXI3 master port, read address
    output logic [AXI_ID_W-1:0]             arid,
    output logic [ADDR_W-1:0]               araddr,
    output logic [3:0]                      arlen,
    output logic [2:0]                      arsize,
    output logic [1:0]                      arburst,
    output logic [1:0]                      arlock,
    output logic [3:0]                      arcache,
    output logic [2:0]                      arprot,
    output logic                            arvalid,
    input  logic                            arready,
    // AXI3 read data
    input  logic [AXI_ID_W-1:0]             rid,
    input  logic [DATA_W-1:0]               rdata,
    input  logic [1:0]                      rresp,
    input  logic                            rlast,
    input  logic                            rvalid,
    output logic                            rready,
    // AXI3 write address
    output logic [AXI_ID_W-1:0]             awid,
    output logic [ADDR_W-1:0]               awaddr,
    output logic [3:0]                      awlen,
    output logic [2:0]                      awsize,
    output logic [1:0]                      awburst,
    output logic [1:0]                      awlock,
    output logic [3:0]                      awcache,
    output logic [2:0]                      awprot,
    output logic                            awvalid,
    input  logic                            awready,
    // AXI3 write data
    output logic [AXI_ID_W-1:0]             wid,
    output logic [DATA_W-1:0]               wdata,
    output logic [DATA_W/8-1:0]             wstrb,
    output logic                            wlast,
    output logic                            wvalid,
    input  logic                            wready,
    // AXI3 write response
    input  logic [AXI_ID_W-1:0]             bid,
    input  logic [1:0]                      bresp,
    input  logic                            bvalid,
    output logic                            bready
);

    localparam int IDX_W  = grant_idx_w(NUM_MASTERS);
    localparam int STRB_W = DATA_W / 8;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MASTERS - 1);

    rd_state_e              rd_state, rd_state_nxt;
    wr_state_e              wr_state, wr_state_nxt;
    logic [IDX_W-1:0]       rd_grant, wr_grant;
    logic [IDX_W-1:0]       rd_ptr, wr_ptr;
    logic [NUM_MASTERS-1:0] rd_win, wr_win;
    logic [IDX_W-1:0]       rd_win_idx, wr_win_idx;
    logic                   rd_take, wr_take;
    logic                   rd_done, wr_done;

    // Fixed transaction attributes.
    assign arsize  = axi_size(DATA_W);
    assign awsize  = axi_size(DATA_W);
    assign arburst = AXI_BURST_INCR;
    assign awburst = AXI_BURST_INCR;
    assign arlock  = AXI_LOCK_NORMAL;
    assign awlock  = AXI_LOCK_NORMAL;
    assign arcache = AXI_CACHE_NONE;
    assign awcache = AXI_CACHE_NONE;
    assign arprot  = AXI_PROT_NONE;
    assign awprot  = AXI_PROT_NONE;

    // Responses carry no error handling and IDs are implied by the held grant.
    logic unused_resp;
    assign unused_resp = ^{rid, rresp, bid, bresp};

    assign rd_take = (rd_state == R_IDLE) && (|m_arvalid);
    assign wr_take = (wr_state == W_IDLE) && (|m_awvalid);
    assign rd_done = (rd_state == R_DATA) && rvalid && rlast;
    assign wr_done = (wr_state == W_RESP) && bvalid;

    rr_arbiter #(.N(NUM_MASTERS), .IDX_W(IDX_W)) u_rd_arb (
        .req       (m_arvalid),
        .ptr       (rd_ptr),
        .grant     (rd_win),
        .grant_idx (rd_win_idx)
    );

    rr_arbiter #(.N(NUM_MASTERS), .IDX_W(IDX_W)) u_wr_arb (
        .req       (m_awvalid),
        .ptr       (wr_ptr),
        .grant     (wr_win),
        .grant_idx (wr_win_idx)
    );

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Advance each channel's pointer past the master whose burst just completed.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (rd_done) rd_ptr <= (rd_grant == LAST_IDX) ? '0 : rd_grant + 1'b1;
            if (wr_done) wr_ptr <= (wr_grant == LAST_IDX) ? '0 : wr_grant + 1'b1;
        end
    end
`else
    assign rd_ptr = '0;
    assign wr_ptr = '0;
`endif

    // ---------------- Read channel ----------------

    // Read FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (!resetn) rd_state <= R_IDLE;
        else         rd_state <= rd_state_nxt;
    end

    // Latch the winner's address, length and index when the grant is taken.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_grant <= '0;
            araddr   <= '0;
            arlen    <= '0;
        end else if (rd_take) begin
            rd_grant <= rd_win_idx;
            araddr   <= m_araddr[int'(rd_win_idx)*ADDR_W +: ADDR_W];
            arlen    <= m_arlen[int'(rd_win_idx)*4 +: 4];
        end
    end

    // Read next-state and handshake routing to the granted master.
    always_comb begin
        rd_state_nxt = rd_state;
        m_arready    = '0;
        arvalid      = 1'b0;
        rready       = 1'b0;
        m_rvalid     = '0;
        m_rlast      = '0;
        case (rd_state)
            R_IDLE: begin
                if (|m_arvalid) begin
                    m_arready    = rd_win;
                    rd_state_nxt = R_ADDR;
                end
            end
            R_ADDR: begin
                arvalid = 1'b1;
                if (arready) rd_state_nxt = R_DATA;
            end
            R_DATA: begin
                rready             = 1'b1;
                m_rvalid[rd_grant] = rvalid;
                m_rlast[rd_grant]  = rlast;
                if (rvalid && rlast) rd_state_nxt = R_IDLE;
            end
            default: rd_state_nxt = R_IDLE;
        endcase
    end

    assign arid    = AXI_ID_W'(rd_grant);
    assign m_rdata = rdata;

    // ---------------- Write channel ----------------

    // Write FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) wr_state <= W_IDLE;
        else         wr_state <= wr_state_nxt;
    end

    // Latch the winner's address, length and index when the grant is taken.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_grant <= '0;
            awaddr   <= '0;
            awlen    <= '0;
        end else if (wr_take) begin
            wr_grant <= wr_win_idx;
            awaddr   <= m_awaddr[int'(wr_win_idx)*ADDR_W +: ADDR_W];
            awlen    <= m_awlen[int'(wr_win_idx)*4 +: 4];
        end
    end

    // Write next-state and handshake routing to the granted master.
    always_comb begin
        wr_state_nxt = wr_state;
        m_awready    = '0;
        awvalid      = 1'b0;
        wvalid       = 1'b0;
        wlast        = 1'b0;
        m_wready     = '0;
        bready       = 1'b0;
        m_bvalid     = '0;
        case (wr_state)
            W_IDLE: begin
                if (|m_awvalid) begin
                    m_awready    = wr_win;
                    wr_state_nxt = W_ADDR;
                end
            end
            W_ADDR: begin
                awvalid = 1'b1;
                if (awready) wr_state_nxt = W_DATA;
            end
            W_DATA: begin
                wvalid             = m_wvalid[wr_grant];
                wlast              = m_wlast[wr_grant];
                m_wready[wr_grant] = wready;
                if (m_wvalid[wr_grant] && wready && m_wlast[wr_grant]) wr_state_nxt = W_RESP;
            end
            W_RESP: begin
                bready             = 1'b1;
                m_bvalid[wr_grant] = bvalid;
                if (bvalid) wr_state_nxt = W_IDLE;
            end
            default: wr_state_nxt = W_IDLE;
        endcase
    end

    assign awid  = AXI_ID_W'(wr_grant);
    assign wid   = AXI_ID_W'(wr_grant);
    assign wdata = m_wdata[int'(wr_grant)*DATA_W +: DATA_W];
    assign wstrb = m_wstrb[int'(wr_grant)*STRB_W +: STRB_W];

endmodule

// File: tb/tb_mem_axi_arbiter.sv
// Directed bench for mem_axi_arbiter: a table of single-master read/write
// bursts plus hand-written sequences for contention, overlap and reset.
module tb_mem_axi_arbiter;
    import mem_arb_pkg::*;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic clk, resetn;
    logic [N-1:0]      m_arvalid, m_arready, m_rvalid, m_rlast;
    logic [N*AW-1:0]   m_araddr, m_awaddr;
    logic [N*4-1:0]    m_arlen, m_awlen;
    logic [DW-1:0]     m_rdata;
    logic [N-1:0]      m_awvalid, m_awready, m_wvalid, m_wlast, m_wready, m_bvalid;
    logic [N*DW-1:0]   m_wdata;
    logic [N*SW-1:0]   m_wstrb;
    logic [AXI_ID_W-1:0] arid, awid, wid, rid, bid;
    logic [AW-1:0]     araddr, awaddr;
    logic [3:0]        arlen, awlen, arcache, awcache;
    logic [2:0]        arsize, awsize, arprot, awprot;
    logic [1:0]        arburst, awburst, arlock, awlock, rresp, bresp;
    logic              arvalid, arready, rlast, rvalid, rready;
    logic              awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [DW-1:0]     rdata, wdata;
    logic [SW-1:0]     wstrb;

    mem_axi_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .resetn(resetn),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
        .m_rvalid(m_rvalid), .m_rlast(m_rlast), .m_rdata(m_rdata),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wlast(m_wlast),
        .m_wready(m_wready), .m_bvalid(m_bvalid),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic clear_inputs;
        m_arvalid = '0; m_araddr = '0; m_arlen = '0;
        m_awvalid = '0; m_awaddr = '0; m_awlen = '0;
        m_wdata = '0; m_wstrb = '0; m_wvalid = '0; m_wlast = '0;
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = '0; rid = '0; rresp = '0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bid = '0; bresp = '0;
    endtask

    task automatic apply_reset;
        resetn = 1'b0;
        clear_inputs();
        tick();
        tick();
        resetn = 1'b1;
    endtask

    // One read burst from master m, slave side driven by the bench.
    task automatic do_read(input int m, input logic [31:0] addr, input logic [3:0] len,
                           input int stall, input logic [3:0] exp_id);
        logic [N-1:0] onehot, exp_last;
        bit granted;
        onehot  = N'(1) << m;
        m_arvalid[m] = 1'b1;
        m_araddr[m*AW +: AW] = addr;
        m_arlen[m*4 +: 4] = len;
        granted = 1'b0;
        for (int c = 0; c < 20 && !granted; c++) begin
            settle();
            if (m_arready[m]) granted = 1'b1;
            else tick();
        end
        check("rd_grant", m_arready, onehot);
        if (!granted) begin
            m_arvalid[m] = 1'b0;
            return;
        end
        tick();
        m_arvalid[m] = 1'b0;
        settle();
        check("rd_addr_phase", {arvalid, araddr, arlen, arid}, {1'b1, addr, len, exp_id});
        // A stray rvalid while the address is still pending must not leak through.
        for (int s = 0; s < stall; s++) begin
            rvalid = 1'b1;
            rdata  = 32'hDEAD_BEEF;
            tick();
            settle();
            check("rd_stall", {arvalid, araddr, m_rvalid}, {1'b1, addr, N'(0)});
        end
        rvalid  = 1'b0;
        arready = 1'b1;
        tick();
        arready = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            rvalid = 1'b1;
            rlast  = (b == int'(len));
            rdata  = 32'hC0DE_0000 | 32'(b);
            exp_last = (b == int'(len)) ? onehot : '0;
            settle();
            check("rd_beat", {rready, m_rvalid, m_rlast, m_rdata},
                  {1'b1, onehot, exp_last, 32'hC0DE_0000 | 32'(b)});
            tick();
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        settle();
        check("rd_end", {rready, arvalid, m_rvalid}, {1'b0, 1'b0, N'(0)});
    endtask

    // One write burst from master m; wready optionally toggles every cycle.
    task automatic do_write(input int m, input logic [31:0] addr, input logic [3:0] len,
                            input logic [3:0] strb, input int toggle, input logic [3:0] exp_id);
        logic [N-1:0] onehot;
        bit granted;
        int beat;
        onehot = N'(1) << m;
        m_awvalid[m] = 1'b1;
        m_awaddr[m*AW +: AW] = addr;
        m_awlen[m*4 +: 4] = len;
        granted = 1'b0;
        for (int c = 0; c < 20 && !granted; c++) begin
            settle();
            if (m_awready[m]) granted = 1'b1;
            else tick();
        end
        check("wr_grant", m_awready, onehot);
        if (!granted) begin
            m_awvalid[m] = 1'b0;
            return;
        end
        tick();
        m_awvalid[m] = 1'b0;
        settle();
        check("wr_addr_phase", {awvalid, awaddr, awlen, awid, wid},
              {1'b1, addr, len, exp_id, exp_id});
        awready = 1'b1;
        tick();
        awready = 1'b0;
        beat = 0;
        for (int c = 0; c < 40 && beat <= int'(len); c++) begin
            m_wvalid[m] = 1'b1;
            m_wdata[m*DW +: DW] = 32'hA5A5_0000 | 32'(beat);
            m_wstrb[m*SW +: SW] = strb;
            m_wlast[m] = (beat == int'(len));
            wready = (toggle != 0) ? (c % 2 == 1) : 1'b1;
            settle();
            check("wr_beat", {wvalid, wlast, wdata, wstrb, m_wready},
                  {1'b1, beat == int'(len), 32'hA5A5_0000 | 32'(beat), strb,
                   wready ? onehot : N'(0)});
            if (wready) beat++;
            tick();
        end
        m_wvalid[m] = 1'b0;
        m_wlast[m]  = 1'b0;
        wready      = 1'b0;
        check("wr_beat_count", 64'(beat), 64'(int'(len) + 1));
        settle();
        check("wr_resp_wait", {bready, m_bvalid, wvalid}, {1'b1, N'(0), 1'b0});
        bvalid = 1'b1;
        settle();
        check("wr_bvalid", m_bvalid, onehot);
        tick();
        bvalid = 1'b0;
        settle();
        check("wr_end", {bready, awvalid, m_bvalid}, {1'b0, 1'b0, N'(0)});
    endtask

    typedef struct {
        bit          wr;
        int          master;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [3:0]  strb;
        int          opt;     // read: arready stall cycles; write: wready toggles
        logic [3:0]  exp_id;
    } vec_t;

    vec_t vecs[6];

    logic [N-1:0]  sim_exp[3];
    logic [31:0]   sim_addr[3];

    bit overlap_seen, rd_started, b_after_rd;
    int bcnt;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b0, 1, 32'h1FC0_0100, 4'd3,  4'h0, 0, 4'd1};
        vecs[1] = '{1'b0, 0, 32'h0000_1000, 4'd0,  4'h0, 0, 4'd0};
        vecs[2] = '{1'b0, 1, 32'h8000_0040, 4'd15, 4'h0, 0, 4'd1};
        vecs[3] = '{1'b0, 0, 32'h1234_5670, 4'd1,  4'h0, 5, 4'd0};
        vecs[4] = '{1'b1, 1, 32'h1FC0_0300, 4'd3,  4'hF, 1, 4'd1};
        vecs[5] = '{1'b1, 0, 32'h0000_2000, 4'd0,  4'h3, 0, 4'd0};

        resetn = 1'b0;
        clear_inputs();
        #1;
        check("reset_handshakes",
              {arvalid, awvalid, rready, wvalid, bready, wlast,
               m_arready, m_awready, m_rvalid, m_rlast, m_wready, m_bvalid}, 64'h0);
        check("reset_regs", {araddr, arlen, arid, awaddr, awlen, awid}, 64'h0);
        check("axi_consts", {arburst, awburst, arsize, awsize, arlock, awlock,
                             arcache, awcache, arprot, awprot},
              {2'b01, 2'b01, 3'd2, 3'd2, 2'b00, 2'b00, 4'h0, 4'h0, 3'd0, 3'd0});
        tick();
        tick();
        resetn = 1'b1;

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].wr)
                do_write(vecs[i].master, vecs[i].addr, vecs[i].len, vecs[i].strb,
                         vecs[i].opt, vecs[i].exp_id);
            else
                do_read(vecs[i].master, vecs[i].addr, vecs[i].len, vecs[i].opt,
                        vecs[i].exp_id);
        end

        // Both masters request continuously for three read grants.
        apply_reset();
`ifdef MEM_ARB_ROUND_ROBIN_EN
        sim_exp[0] = 2'b01; sim_exp[1] = 2'b10; sim_exp[2] = 2'b01;
`else
        sim_exp[0] = 2'b01; sim_exp[1] = 2'b01; sim_exp[2] = 2'b01;
`endif
        for (int r = 0; r < 3; r++) sim_addr[r] = sim_exp[r][1] ? 32'h0000_0200 : 32'h0000_0100;
        m_araddr  = {32'h0000_0200, 32'h0000_0100};
        m_arlen   = '0;
        m_arvalid = 2'b11;
        for (int r = 0; r < 3; r++) begin
            settle();
            check("contend_grant", m_arready, sim_exp[r]);
            tick();
            settle();
            check("contend_addr", {araddr, arid}, {sim_addr[r], sim_exp[r][1] ? 4'd1 : 4'd0});
            arready = 1'b1;
            tick();
            arready = 1'b0;
            rvalid  = 1'b1;
            rlast   = 1'b1;
            settle();
            check("contend_route", m_rvalid, sim_exp[r]);
            tick();
            rvalid = 1'b0;
            rlast  = 1'b0;
        end
        m_arvalid = '0;

        // Icache refill overlapped with a Dcache write-back.
        tick();
        overlap_seen = 1'b0;
        rd_started   = 1'b0;
        b_after_rd   = 1'b0;
        bcnt         = 0;
        fork
            do_read(0, 32'h1FC0_0400, 4'd7, 0, 4'd0);
            do_write(1, 32'h0000_3000, 4'd3, 4'hF, 0, 4'd1);
            begin
                for (int c = 0; c < 40; c++) begin
                    @(negedge clk);
                    if (rready && (awvalid || wvalid || bready)) overlap_seen = 1'b1;
                    if (m_rvalid[0]) rd_started = 1'b1;
                    if (m_bvalid[1]) begin
                        bcnt++;
                        if (rd_started) b_after_rd = 1'b1;
                    end
                end
            end
        join
        check("overlap_inflight", overlap_seen, 1'b1);
        check("overlap_bvalid_count", 64'(bcnt), 64'd1);
        check("overlap_b_after_read", b_after_rd, 1'b1);

        // Reset asserted during beat 2 of a read.
        tick();
        m_arvalid[0] = 1'b1;
        m_araddr[0 +: AW] = 32'h0000_5000;
        m_arlen[0 +: 4] = 4'd3;
        settle();
        check("rst_seq_grant", m_arready, 2'b01);
        tick();
        m_arvalid[0] = 1'b0;
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rvalid  = 1'b1;
        rdata   = 32'h1111_0000;
        tick();
        rdata   = 32'h1111_0001;
        settle();
        check("rst_seq_beat2", m_rvalid, 2'b01);
        resetn = 1'b0;
        #1;
        check("rst_async_handshakes",
              {arvalid, awvalid, rready, wvalid, bready,
               m_arready, m_awready, m_rvalid, m_rlast, m_wready, m_bvalid}, 64'h0);
        check("rst_async_regs", {araddr, arlen, arid}, 64'h0);
        rvalid = 1'b0;
        tick();
        resetn = 1'b1;
        do_read(1, 32'h1FC0_0200, 4'd1, 0, 4'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
